// File: rtl/key_debounce_if.sv
// Key debouncer signal bundle: raw button level in, clean level and edge strobes out.
// The master side is the debouncer; the slave side is the key source / downstream consumer.
interface key_debounce_if;
  logic key_in;
  logic key_level;
  logic key_press;
  logic key_release;

  modport master (
    input  key_in,
    output key_level,
    output key_press,
    output key_release
  );

  modport slave (
    output key_in,
    input  key_level,
    input  key_press,
    input  key_release
  );
endinterface

// File: rtl/key_debounce.sv
// Single-key debouncer: two-flop synchroniser followed by a stable-count FSM that
// emits a registered clean level plus one-cycle press/release strobes.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd1000000,
  parameter bit          ACTIVE_LOW      = 1'b0,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 32'd1)
) (
  input  logic           clk,
  input  logic           reset,
  key_debounce_if.master key
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);

  logic             key_s;
  logic             sync1_r;
  logic             sync2_r;
  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             level_r;
  logic             press_r;
  logic             release_r;

  // Polarity normalisation so a pressed key is always 1 internally.
  assign key_s = key.key_in ^ ACTIVE_LOW;

  // Two-flop synchroniser for the asynchronous button level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= key_s;
      sync2_r <= sync1_r;
    end
  end

  // Debounce FSM: any opposite sample falls back to the last stable state,
  // so a change is accepted only after an unbroken run of matching samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      press_r   <= 1'b0;
      release_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (sync2_r) begin
            state_r <= DEB_PRESS;
            cnt_r   <= CNT_ZERO;
          end
        end
        DEB_PRESS: begin
          if (!sync2_r) begin
            state_r <= IDLE;
          end else if (cnt_r == CNT_MAX) begin
            state_r <= PRESSED;
            level_r <= 1'b1;
            press_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!sync2_r) begin
            state_r <= DEB_RELEASE;
            cnt_r   <= CNT_ZERO;
          end
        end
        DEB_RELEASE: begin
          if (sync2_r) begin
            state_r <= PRESSED;
          end else if (cnt_r == CNT_MAX) begin
            state_r   <= IDLE;
            level_r   <= 1'b0;
            release_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= CNT_ZERO;
          level_r <= 1'b0;
        end
      endcase
    end
  end

  assign key.key_level   = level_r;
  assign key.key_press   = press_r;
  assign key.key_release = release_r;

endmodule
